// File: rtl/display_scan.sv
// display_scan: time-multiplexed 8x8 red/green matrix and 8-digit 7-segment scan driver.
module display_scan #(
  parameter int CLK_DIV   = 12500,
  parameter int BLANK_CYC = 8
) (
  input  logic         clk,
  input  logic         sw,
  input  logic [127:0] matrixData,
  input  logic [31:0]  numbersData,
  output logic [7:0]   row,
  output logic [7:0]   colR,
  output logic [7:0]   colG,
  output logic [7:0]   digSel,
  output logic [7:0]   seg,
  output logic         frameStart
);
  localparam int DW = $clog2(CLK_DIV);
  logic [DW-1:0] div_q, div_d;
  logic [2:0]    idx_q, idx_d;
  logic [127:0]  snap_m_q, snap_m_d;
  logic [31:0]   snap_n_q, snap_n_d;
  logic [7:0]    row_q, row_d, col_r_q, col_r_d, col_g_q, col_g_d;
  logic [7:0]    dig_q, dig_d, seg_q, seg_d;
  logic          fs_q, fs_d;
  logic          tick, blank;
  logic [15:0]   pix;
  logic [3:0]    nib;
  logic [7:0]    sel, glyph, r_bits, g_bits;
  always_comb begin
    tick     = div_q == DW'(CLK_DIV - 1);
    blank    = div_q < DW'(BLANK_CYC);
    div_d    = tick ? '0 : div_q + 1'b1;
    idx_d    = tick ? idx_q + 3'd1 : idx_q;
    snap_m_d = (tick && idx_q == 3'd7) ? matrixData : snap_m_q;
    snap_n_d = (tick && idx_q == 3'd7) ? numbersData : snap_n_q;
    fs_d     = tick && idx_q == 3'd7;
    pix      = snap_m_q[{idx_q, 4'h0} +: 16];
    nib      = snap_n_q[{idx_q, 2'b00} +: 4];
    sel      = ~(8'd1 << idx_q);
    r_bits   = '0;
    g_bits   = '0;
    for (int c = 0; c < 8; c++) begin
      r_bits[c] = pix[2*c+1];
      g_bits[c] = pix[2*c];
    end
    case (nib)
      4'h0: glyph = 8'h3F;
      4'h1: glyph = 8'h06;
      4'h2: glyph = 8'h5B;
      4'h3: glyph = 8'h4F;
      4'h4: glyph = 8'h66;
      4'h5: glyph = 8'h6D;
      4'h6: glyph = 8'h7D;
      4'h7: glyph = 8'h07;
      4'h8: glyph = 8'h7F;
      4'h9: glyph = 8'h6F;
      4'hA: glyph = 8'h77;
      4'hB: glyph = 8'h7C;
      4'hC: glyph = 8'h39;
      4'hD: glyph = 8'h5E;
      4'hE: glyph = 8'h79;
      default: glyph = 8'h00;
    endcase
    row_d   = blank ? 8'hFF : sel;
    dig_d   = blank ? 8'hFF : sel;
    col_r_d = blank ? 8'h00 : r_bits;
    col_g_d = blank ? 8'h00 : g_bits;
    seg_d   = blank ? 8'h00 : glyph;
  end
  always_ff @(posedge clk or negedge sw) begin
    if (!sw) begin
      div_q    <= '0;
      idx_q    <= '0;
      snap_m_q <= '0;
      snap_n_q <= 32'hFFFF_FFFF;
      row_q    <= 8'hFF;
      col_r_q  <= 8'h00;
      col_g_q  <= 8'h00;
      dig_q    <= 8'hFF;
      seg_q    <= 8'h00;
      fs_q     <= 1'b0;
    end else begin
      div_q    <= div_d;
      idx_q    <= idx_d;
      snap_m_q <= snap_m_d;
      snap_n_q <= snap_n_d;
      row_q    <= row_d;
      col_r_q  <= col_r_d;
      col_g_q  <= col_g_d;
      dig_q    <= dig_d;
      seg_q    <= seg_d;
      fs_q     <= fs_d;
    end
  end
  assign row        = row_q;
  assign colR       = col_r_q;
  assign colG       = col_g_q;
  assign digSel     = dig_q;
  assign seg        = seg_q;
  assign frameStart = fs_q;
endmodule

// File: tb/tb_display_scan.sv
// tb_display_scan: randomized scan check against a cycle-count model of the display driver.
module tb_display_scan;
  localparam int CD = 4;
  localparam int BC = 1;
  localparam int FR = 8 * CD;
  localparam logic [7:0] GLYPH [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                                        8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h00};
  logic clk = 0;
  logic sw = 1;
  logic [127:0] md = '0;
  logic [31:0] nd = '0;
  logic [7:0] row, colR, colG, digSel, seg;
  logic frameStart;
  int checks = 0;
  int failures = 0;
  int cnt = 0;
  logic [127:0] m_snap_m = '0;
  logic [31:0]  m_snap_n = 32'hFFFF_FFFF;
  logic [7:0] e_row = 8'hFF, e_r = 8'h00, e_g = 8'h00, e_dig = 8'hFF, e_seg = 8'h00;
  logic e_fs = 1'b0;

  display_scan #(.CLK_DIV(CD), .BLANK_CYC(BC)) dut (
    .clk(clk), .sw(sw), .matrixData(md), .numbersData(nd),
    .row(row), .colR(colR), .colG(colG), .digSel(digSel), .seg(seg), .frameStart(frameStart)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t got=%02h want=%02h", name, $time, act, exp);
    end
  endtask

  always @(negedge sw) begin
    cnt = 0;
    m_snap_m = '0;
    m_snap_n = 32'hFFFF_FFFF;
    e_row = 8'hFF; e_r = 8'h00; e_g = 8'h00; e_dig = 8'hFF; e_seg = 8'h00; e_fs = 1'b0;
  end

  // Expected outputs follow from the number of edges since release: slot = cnt/CD, phase = cnt%CD.
  always @(posedge clk) begin
    if (sw) begin
      int d, s;
      d = cnt % CD;
      s = (cnt / CD) % 8;
      if (d < BC) begin
        e_row = 8'hFF; e_dig = 8'hFF; e_r = 8'h00; e_g = 8'h00; e_seg = 8'h00;
      end else begin
        e_row = ~(8'd1 << s);
        e_dig = e_row;
        for (int c = 0; c < 8; c++) begin
          e_r[c] = m_snap_m[2*(8*s+c)+1];
          e_g[c] = m_snap_m[2*(8*s+c)];
        end
        e_seg = GLYPH[m_snap_n[4*s +: 4]];
      end
      e_fs = (cnt % FR) == FR - 1;
      if (e_fs) begin
        m_snap_m = md;
        m_snap_n = nd;
      end
      cnt++;
    end
    #1;
    chk("row", row, e_row);
    chk("colR", colR, e_r);
    chk("colG", colG, e_g);
    chk("digSel", digSel, e_dig);
    chk("seg", seg, e_seg);
    chk("frameStart", {7'd0, frameStart}, {7'd0, e_fs});
  end

  task automatic wait_fs();
    bit seen = 0;
    for (int i = 0; i < 3 * FR && !seen; i++) begin
      @(posedge clk);
      #1;
      if (frameStart) seen = 1;
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL wait_fs timeout got=0 want=1");
    end
  endtask

  task automatic lit0();
    wait_fs();
    @(posedge clk);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2 sw = 0;
    #1 chk("rst_row", row, 8'hFF);
    chk("rst_dig", digSel, 8'hFF);
    repeat (3) @(negedge clk);
    sw = 1;
    repeat (31) @(posedge clk);
    #1 chk("fs_before", {7'd0, frameStart}, 8'h00);
    @(posedge clk);
    #1 chk("fs_first", {7'd0, frameStart}, 8'h01);
    @(posedge clk);
    #1 chk("f1_blank_dig", digSel, 8'hFF);
    @(posedge clk);
    #1 chk("f1_dig0", digSel, 8'hFE);
    chk("f1_seg0", seg, 8'h3F);
    @(negedge clk) md = {64{2'b10}};
    lit0();
    chk("red_row0", row, 8'hFE);
    chk("red_colR", colR, 8'hFF);
    chk("red_colG", colG, 8'h00);
    @(negedge clk) nd = 32'h0FFF_FFF8;
    lit0();
    chk("nd_seg_d0", seg, 8'h7F);
    @(negedge clk) md = '0;
    wait_fs();
    repeat (13) @(posedge clk);
    @(negedge clk) md = {128{1'b1}};
    @(posedge clk);
    @(posedge clk);
    #1 chk("slot3_colR_stale", colR, 8'h00);
    lit0();
    chk("next_colR", colR, 8'hFF);
    chk("next_colG", colG, 8'hFF);
    wait_fs();
    repeat (22) @(posedge clk);
    #2 sw = 0;
    #1 chk("mid_rst_row", row, 8'hFF);
    chk("mid_rst_colR", colR, 8'h00);
    chk("mid_rst_dig", digSel, 8'hFF);
    chk("mid_rst_seg", seg, 8'h00);
    repeat (2) @(negedge clk);
    sw = 1;
    nd = 32'h0123_4567;
    repeat (2 * FR + FR) @(posedge clk);
    @(negedge clk) nd = 32'h89AB_CDEF;
    repeat (3 * FR) @(posedge clk);
    repeat (400) begin
      @(negedge clk);
      if ($urandom_range(0, 15) == 0) md = {$urandom, $urandom, $urandom, $urandom};
      if ($urandom_range(0, 15) == 0) nd = $urandom;
    end
    @(posedge clk);
    #2;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/display_scan.md
# display_scan

Time-multiplexed output driver for the board's 8×8 red/green LED matrix and 8-digit 7-segment display. Consumes the 128-bit `matrixData` and 32-bit `numbersData` buses produced by the self-test and application stages, and converts them into row/column and digit/segment scan signals. Inputs are snapshotted once per frame so pixels and digits never tear mid-frame.

## Interface
- `CLK_DIV`, 12500: clocks per scan slot; legal range ≥ 2. The default gives a 4 kHz slot and 500 Hz frame at 50 MHz.
- `BLANK_CYC`, 8: leading clocks of each slot with all outputs blanked (anti-ghosting); must be < `CLK_DIV`.
- `clk`  in  1: system clock; the only clock.
- `sw`  in  1: reset; asynchronous and active-low.
- `matrixData`  in  128: pixel p = 8·r+c; bit 2p+1 = red and bit 2p = green for row r, column c.
- `numbersData`  in  32: nibble k (bits 4k+3:4k) = digit k; digit 7 is leftmost; value 4'hF = blank.
- `row`  out  8: matrix row select, active-low one-hot; bit r = row r.
- `colR`  out  8: red column data for the selected row, active-high; bit c = column c.
- `colG`  out  8: green column data for the selected row, active-high.
- `digSel`  out  8: digit select, active-low one-hot; bit k = digit k.
- `seg`  out  8: segments {dp,g,f,e,d,c,b,a}, active-high.
- `frameStart`  out  1: one-clock pulse when a new frame begins.

## Operation
- `div` counts 0..`CLK_DIV`-1 and wraps. A tick is the clock edge where `div`==`CLK_DIV`-1.
- `idx` is a 3-bit slot index. It increments on each tick and wraps 7→0. Matrix row and display digit share `idx`.
- Snapshot registers `snapM` (128 bits) and `snapN` (32 bits) load `matrixData`/`numbersData` on the tick where `idx`==7, so they are fresh for slot 0. `frameStart` is high for the single clock following that edge.
- Per-slot drive, when not blanked:
  - `row` = ~(1<<`idx`).
  - `colR[c]` = `snapM`[2(8·`idx`+c)+1]; `colG[c]` = `snapM`[2(8·`idx`+c)].
  - `digSel` = ~(1<<`idx`).
  - `seg` = glyph(`snapN` nibble `idx`).
- Blanked drive, while `div` < `BLANK_CYC`: `row`=8'hFF, `colR`=`colG`=8'h00, `digSel`=8'hFF, `seg`=8'h00.
- Glyph table (dp always 0):
  - 0:3F, 1:06, 2:5B, 3:4F, 4:66, 5:6D, 6:7D, 7:07
  - 8:7F, 9:6F, A:77, b:7C, C:39, d:5E, E:79, F:00 (blank)
- Input changes outside the `idx`==7 tick have no visible effect until the next frame.

## Timing
- All outputs are registered. The outputs at cycle n are a function of `div`, `idx` and the snapshots at cycle n-1, giving one clock of latency.
- Slot length is exactly `CLK_DIV` clocks and frame length is 8·`CLK_DIV` clocks.
- Each slot has `BLANK_CYC` blank clocks followed by `CLK_DIV`-`BLANK_CYC` lit clocks.
- Reset (`sw`=0, asynchronous) forces, immediately and without a clock:
  - `div`=0, `idx`=0, `snapM`=0, `snapN`=32'hFFFFFFFF.
  - `row`=8'hFF, `colR`=`colG`=8'h00, `digSel`=8'hFF, `seg`=8'h00, `frameStart`=0.
- The first frame after reset release is fully dark and blank. The first snapshot occurs at the end of slot 7, i.e. `frameStart` rises 8·`CLK_DIV` clocks after release.
- Reset asserted mid-slot or mid-frame aborts the scan at once, with no partial slot completed. Restart after release is identical to power-on.
- A change to `matrixData` on the snapshot edge itself is sampled with normal setup and hold; no special handling is required.

## Test plan
Bench parameters unless stated: `CLK_DIV`=4, `BLANK_CYC`=1.
- Reset hold then release, inputs all 0: all outputs keep their reset values through frame 0, and `frameStart` pulses once at clock 32 after release. During frame 1, `digSel` walks FE,FD,…,7F with `seg`=3F on the lit clocks.
- `matrixData`={64{2'b10}}: in frame 1, each slot shows 1 blank clock (`row`=FF) then 3 lit clocks with `row`=~(1<<r), `colR`=FF, `colG`=00.
- `numbersData`=32'h0FFFFFF8, set in frame 1: frame 2 shows `seg`=7F on digit 0, `seg`=3F on digit 7, and `seg`=00 on digits 1–6.
- Change `matrixData` from all-0 to all-1 during slot 3: `colR`/`colG` stay 00 for the rest of that frame and become FF from slot 0 of the next frame.
- Assert `sw`=0 during slot 5 of a lit frame: all outputs return to reset values in the same cycle. After release, one full dark frame precedes valid display.
- Sweep glyphs: `numbersData`=32'h01234567 and then 32'h89ABCDEF, each held for 2 frames. Every `seg` value matches the glyph table for its digit.
